// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Holds data width, register count, zero-register index, grant enum.
package regfile_pkg;

    localparam int WIDTH    = 64;
    localparam int NREGS    = 32;
    localparam int ZERO_REG = 31;

    typedef logic [4:0]       reg_addr_t;
    typedef logic [WIDTH-1:0] word_t;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Valid/ready write-request channel from one requester.
// master: valid/addr/data out, ready in; slave: the reverse.
interface regfile_write_arbiter_if;

    logic                  valid;
    logic                  ready;
    regfile_pkg::reg_addr_t addr;
    regfile_pkg::word_t     data;

    modport master (
        output valid,
        output addr,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  addr,
        input  data,
        output ready
    );

endinterface

// File: rtl/regfile_write_arbiter_decoder.sv
// 5-to-32 one-hot decoder with enable.
// Ports: en, addr in; onehot out (all-zero when en is low).
module decoder_5to32
    import regfile_pkg::*;
(
    input  logic        en,
    input  reg_addr_t   addr,
    output logic [31:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot = 32'd1 << addr;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port (A, B).
// Ports: clk, reset (async low), flush, a/b channels, wr_*, busy.
module regfile_write_arbiter
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    regfile_write_arbiter_if.slave a,
    regfile_write_arbiter_if.slave b,
    output logic [NREGS-1:0]      wr_en,
    output reg_addr_t             wr_addr,
    output word_t                 wr_data,
    output logic                  wr_src,
    output logic                  busy
);

    logic      pend_a, pend_b;
    reg_addr_t a_addr_q, b_addr_q;
    word_t     a_data_q, b_data_q;

    grant_t    last_grant, last_grant_nxt;
    logic      grant_a, grant_b, any_grant;
    reg_addr_t sel_addr;
    word_t     sel_data;
    logic      dec_en;
    logic [NREGS-1:0] dec_out;

    // Tie goes to whoever did not win last time.
    always_comb begin
        grant_a = pend_a & (~pend_b | (last_grant == GRANT_B));
        grant_b = pend_b & (~pend_a | (last_grant == GRANT_A));
    end

    assign any_grant = grant_a | grant_b;
    assign sel_addr  = grant_b ? b_addr_q : a_addr_q;
    assign sel_data  = grant_b ? b_data_q : a_data_q;
    assign dec_en    = any_grant & (sel_addr != reg_addr_t'(ZERO_REG));

    // Draining slot can refill on the same edge.
    assign a.ready = ~pend_a | grant_a;
    assign b.ready = ~pend_b | grant_b;

    assign busy = pend_a | pend_b | (|wr_en);

    decoder_5to32 u_dec (
        .en     (dec_en),
        .addr   (sel_addr),
        .onehot (dec_out)
    );

    always_comb begin
        last_grant_nxt = last_grant;
        if (!flush) begin
            unique case (1'b1)
                grant_a: last_grant_nxt = GRANT_A;
                grant_b: last_grant_nxt = GRANT_B;
                default: last_grant_nxt = last_grant;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= GRANT_B;
        end else begin
            last_grant <= last_grant_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_a   <= 1'b0;
            a_addr_q <= '0;
            a_data_q <= '0;
        end else if (flush) begin
            pend_a <= 1'b0;
        end else if (a.valid && a.ready) begin
            pend_a   <= 1'b1;
            a_addr_q <= a.addr;
            a_data_q <= a.data;
        end else if (grant_a) begin
            pend_a <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_b   <= 1'b0;
            b_addr_q <= '0;
            b_data_q <= '0;
        end else if (flush) begin
            pend_b <= 1'b0;
        end else if (b.valid && b.ready) begin
            pend_b   <= 1'b1;
            b_addr_q <= b.addr;
            b_data_q <= b.data;
        end else if (grant_b) begin
            pend_b <= 1'b0;
        end
    end

    // Zero-register writes still load addr/data; only the enable is masked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en   <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_src  <= 1'b0;
        end else if (flush) begin
            wr_en <= '0;
        end else if (any_grant) begin
            wr_en   <= dec_out;
            wr_addr <= sel_addr;
            wr_data <= sel_data;
            wr_src  <= grant_b;
        end else begin
            wr_en <= '0;
        end
    end

    a_onehot: assert property (
        @(posedge clk) disable iff (!reset) $onehot0(wr_en));

    a_no_zero: assert property (
        @(posedge clk) disable iff (!reset) !wr_en[ZERO_REG]);

    a_hold_a: assert property (
        @(posedge clk) disable iff (!reset)
        (a.valid && !a.ready) |=> ($stable(a.addr) && $stable(a.data)));

    a_hold_b: assert property (
        @(posedge clk) disable iff (!reset)
        (b.valid && !b.ready) |=> ($stable(b.addr) && $stable(b.data)));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter.
// Linear stimulus, immediate assertions, one summary line.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    logic             clk;
    logic             reset;
    logic             flush;
    logic [NREGS-1:0] wr_en;
    reg_addr_t        wr_addr;
    word_t            wr_data;
    logic             wr_src;
    logic             busy;

    int n_vec;
    int n_err;

    regfile_write_arbiter_if a_if ();
    regfile_write_arbiter_if b_if ();

    regfile_write_arbiter dut (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .a       (a_if),
        .b       (b_if),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_src  (wr_src),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        flush = 1'b0;
        a_if.valid = 1'b0;
        a_if.addr  = '0;
        a_if.data  = '0;
        b_if.valid = 1'b0;
        b_if.addr  = '0;
        b_if.data  = '0;

        // reset and first A write
        tick; tick; tick;
        reset = 1'b1;
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_a_ready", 64'(a_if.ready), 64'd1);
        chk("rst_b_ready", 64'(b_if.ready), 64'd1);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        a_if.valid = 1'b1;
        a_if.addr  = 5'd5;
        a_if.data  = 64'h1234;
        tick;
        a_if.valid = 1'b0;
        chk("lat_e1_wr_en", 64'(wr_en), 64'd0);
        chk("lat_e1_busy", 64'(busy), 64'd1);
        tick;
        chk("lat_wr_en", 64'(wr_en), 64'h20);
        chk("lat_wr_data", 64'(wr_data), 64'h1234);
        chk("lat_wr_src", 64'(wr_src), 64'd0);
        chk("lat_wr_addr", 64'(wr_addr), 64'd5);
        tick;
        chk("lat_idle_en", 64'(wr_en), 64'd0);
        chk("lat_idle_busy", 64'(busy), 64'd0);

        // fresh reset: last_grant = B, A wins first tie
        reset = 1'b0;
        tick;
        reset = 1'b1;
        a_if.valid = 1'b1;
        a_if.addr  = 5'd1;
        a_if.data  = 64'hA1;
        b_if.valid = 1'b1;
        b_if.addr  = 5'd2;
        b_if.data  = 64'hB2;
        tick;
        chk("rr_e1_a_ready", 64'(a_if.ready), 64'd1);
        chk("rr_e1_b_ready", 64'(b_if.ready), 64'd0);
        chk("rr_e1_wr_en", 64'(wr_en), 64'd0);
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("rr_src", 64'(wr_src), 64'(i % 2));
            chk("rr_wr_en", 64'(wr_en),
                (i % 2 == 1) ? 64'h4 : 64'h2);
            chk("rr_a_ready", 64'(a_if.ready), 64'(i % 2 == 1));
            chk("rr_b_ready", 64'(b_if.ready), 64'(i % 2 == 0));
        end
        a_if.valid = 1'b0;
        b_if.valid = 1'b0;
        tick;
        chk("rr_drain_a", 64'(wr_en), 64'h2);
        tick;
        chk("rr_drain_b", 64'(wr_en), 64'h4);
        chk("rr_drain_b_data", 64'(wr_data), 64'hB2);
        tick;
        chk("rr_idle_busy", 64'(busy), 64'd0);

        // A-only full throughput, addrs 0..7
        for (int i = 0; i < 8; i++) begin
            a_if.valid = 1'b1;
            a_if.addr  = 5'(i);
            a_if.data  = 64'(i + 256);
            chk("tp_a_ready", 64'(a_if.ready), 64'd1);
            tick;
            if (i > 0) begin
                chk("tp_wr_en", 64'(wr_en), 64'd1 << (i - 1));
            end
        end
        a_if.valid = 1'b0;
        tick;
        chk("tp_wr_en_last", 64'(wr_en), 64'h80);
        chk("tp_data_last", 64'(wr_data), 64'h107);
        tick;
        chk("tp_idle", 64'(wr_en), 64'd0);

        // B write to zero register is swallowed
        b_if.valid = 1'b1;
        b_if.addr  = 5'd31;
        b_if.data  = 64'hFFFF;
        tick;
        b_if.valid = 1'b0;
        chk("z_e1_wr_en", 64'(wr_en), 64'd0);
        chk("z_e1_busy", 64'(busy), 64'd1);
        chk("z_e1_b_ready", 64'(b_if.ready), 64'd1);
        tick;
        chk("z_e2_wr_en", 64'(wr_en), 64'd0);
        chk("z_e2_busy", 64'(busy), 64'd0);
        chk("z_e2_src", 64'(wr_src), 64'd1);
        chk("z_e2_b_ready", 64'(b_if.ready), 64'd1);
        tick;
        chk("z_e3_wr_en", 64'(wr_en), 64'd0);

        // set last_grant = A, then same address on both
        a_if.valid = 1'b1;
        a_if.addr  = 5'd3;
        a_if.data  = 64'h33;
        tick;
        a_if.valid = 1'b0;
        tick;
        chk("sa_prep_en", 64'(wr_en), 64'h8);
        tick;
        a_if.valid = 1'b1;
        a_if.addr  = 5'd9;
        a_if.data  = 64'hAA;
        b_if.valid = 1'b1;
        b_if.addr  = 5'd9;
        b_if.data  = 64'hBB;
        tick;
        a_if.valid = 1'b0;
        b_if.valid = 1'b0;
        tick;
        chk("sa_first_en", 64'(wr_en), 64'h200);
        chk("sa_first_data", 64'(wr_data), 64'hBB);
        chk("sa_first_src", 64'(wr_src), 64'd1);
        tick;
        chk("sa_second_en", 64'(wr_en), 64'h200);
        chk("sa_second_data", 64'(wr_data), 64'hAA);
        chk("sa_second_src", 64'(wr_src), 64'd0);
        tick;
        chk("sa_idle", 64'(wr_en), 64'd0);

        // flush with two pending (last_grant = A)
        a_if.valid = 1'b1;
        a_if.addr  = 5'd4;
        a_if.data  = 64'h44;
        b_if.valid = 1'b1;
        b_if.addr  = 5'd6;
        b_if.data  = 64'h66;
        tick;
        a_if.valid = 1'b0;
        chk("fl_pre_busy", 64'(busy), 64'd1);
        b_if.addr  = 5'd8;
        b_if.data  = 64'h88;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        b_if.valid = 1'b0;
        chk("fl_busy", 64'(busy), 64'd0);
        chk("fl_wr_en", 64'(wr_en), 64'd0);
        chk("fl_a_ready", 64'(a_if.ready), 64'd1);
        chk("fl_b_ready", 64'(b_if.ready), 64'd1);
        tick;
        chk("fl_no_pulse", 64'(wr_en), 64'd0);
        chk("fl_busy2", 64'(busy), 64'd0);
        // last_grant kept at A across flush -> B wins tie
        a_if.valid = 1'b1;
        b_if.valid = 1'b1;
        tick;
        a_if.valid = 1'b0;
        b_if.valid = 1'b0;
        tick;
        chk("fl_lg_src", 64'(wr_src), 64'd1);
        chk("fl_lg_en", 64'(wr_en), 64'h100);
        tick;
        chk("fl_lg_src2", 64'(wr_src), 64'd0);
        chk("fl_lg_en2", 64'(wr_en), 64'h10);
        tick;

        // async reset while wr_en = 0x8 with B pending
        a_if.valid = 1'b1;
        a_if.addr  = 5'd3;
        a_if.data  = 64'h3;
        tick;
        a_if.valid = 1'b0;
        b_if.valid = 1'b1;
        b_if.addr  = 5'd10;
        b_if.data  = 64'hA;
        tick;
        b_if.valid = 1'b0;
        chk("ar_pre_en", 64'(wr_en), 64'h8);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_now_en", 64'(wr_en), 64'd0);
        chk("ar_now_busy", 64'(busy), 64'd0);
        #2;
        reset = 1'b1;
        tick;
        chk("ar_e1_en", 64'(wr_en), 64'd0);
        chk("ar_e1_busy", 64'(busy), 64'd0);
        tick;
        chk("ar_e2_en", 64'(wr_en), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between two writers: A = pipeline writeback, B = multi-cycle unit (mul/div).
- Each requester uses a valid/ready handshake into a one-entry holding buffer.
- A round-robin arbiter drains the buffers and produces registered one-hot write enables and data.
- The outputs drive the `en` / `d` inputs of the 32 per-register 64-bit enable registers in the register file.

Parameters:
- WIDTH, 64, data width per register
- NREGS, 32, number of architectural registers
- ZERO_REG, 31, hard-wired zero register index; writes to it are discarded

Ports:
- clk  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- flush  in  1  synchronous clear of pending buffers and output stage
- a_valid  in  1  requester A has a write
- a_ready  out  1  A buffer can accept this cycle
- a_addr  in  5  A destination register
- a_data  in  WIDTH  A write data
- b_valid  in  1  requester B has a write
- b_ready  out  1  B buffer can accept this cycle
- b_addr  in  5  B destination register
- b_data  in  WIDTH  B write data
- wr_en  out  NREGS  one-hot per-register write enable, at most one bit set
- wr_addr  out  5  index of the register being written
- wr_data  out  WIDTH  data broadcast to all registers
- wr_src  out  1  0 = current write came from A, 1 = from B
- busy  out  1  pend_a | pend_b | (|wr_en)

Behaviour:
- State:
  - pend_a / pend_b: valid bit plus addr/data per buffer.
  - last_grant FSM with states GRANT_A and GRANT_B.
  - Output registers: wr_en, wr_addr, wr_data, wr_src.
- Reset (reset == 0, asynchronous):
  - pend_a = pend_b = 0.
  - wr_en = 0, wr_addr = 0, wr_data = 0, wr_src = 0.
  - last_grant = GRANT_B, so A wins the first tie.
  - a_ready = b_ready = 1 from the first cycle after reset deasserts.
- Grant (combinational from the current state):
  - Only pend_a set: grant A.
  - Only pend_b set: grant B.
  - Both set: grant the one not equal to last_grant.
  - Neither set: no grant.
- Ready (combinational, no dependency on valid):
  - a_ready = ~pend_a | grant_a.
  - b_ready = ~pend_b | grant_b.
  - A buffer being drained this cycle can accept a new entry in the same cycle.
- Posedge with a grant to X:
  - Output registers load from X's buffer; wr_src = X.
  - wr_en = one-hot(addr), or all-zero if addr == ZERO_REG. The buffer is still consumed.
  - last_grant <= X.
  - X's pending bit clears unless a new X request is accepted on the same edge, in which case the buffer reloads.
- Posedge with no grant: wr_en <= 0. wr_addr, wr_data and wr_src hold.
- Accept: on a posedge where X_valid & X_ready, X's buffer loads addr/data and pend_X <= 1.
- Latency:
  - Request accepted at edge E.
  - wr_en is asserted during the cycle after edge E+1.
  - The register file captures the data at edge E+2.
  - Sustained throughput is one write per cycle, total across both requesters.
- Same address pending on both: writes occur in grant order, so the later-granted value is the final register value. There is no merging.
- Flush (synchronous, highest priority):
  - Clears pend_a, pend_b and wr_en.
  - Requests presented in the flush cycle are dropped.
  - last_grant is unchanged.
- Reset mid-operation: all pending writes and any in-flight wr_en are discarded immediately.
- Invariants (checked by assertions):
  - $onehot0(wr_en).
  - wr_en[ZERO_REG] is never 1.
  - While X_valid & ~X_ready, the requester must hold addr/data stable.

Decomposition:
- Package regfile_pkg:
  - Constants NREGS and ZERO_REG.
  - typedef reg_addr_t, a 5-bit register index.
  - typedef word_t [WIDTH-1:0].
  - enum grant_t {GRANT_A, GRANT_B}.
- Sub-module decoder_5to32 (inputs en, addr; output one-hot[31:0]).
  - Instantiated once with en = grant & (addr != ZERO_REG).

Test Plan:
- Reset held low 3 cycles, then released -> wr_en = 0, busy = 0, a_ready = b_ready = 1. Then a_valid with addr 5, data 0x1234 for 1 cycle -> wr_en = 0x0000_0020, wr_data = 0x1234, wr_src = 0 exactly 2 edges after acceptance.
- A and B both valid every cycle, A addr 1, B addr 2, 6 cycles -> wr_src alternates 0,1,0,1 with A first; wr_en alternates 0x2 / 0x4; readies show one stall per requester per 2 cycles.
- Only A valid for 8 consecutive cycles, addrs 0..7 -> a_ready stays 1; wr_en = 1<<i on 8 consecutive cycles (full throughput).
- B write to addr 31, data 0xFFFF -> buffer consumed, b_ready recovers, wr_en stays 0 for the whole sequence.
- A and B both pending with addr 9, A data 0xAA, B data 0xBB, last_grant = GRANT_A -> B written first, then A; the final register 9 write carries 0xAA.
- Two pending entries, then flush for 1 cycle; separately, reset pulsed low asynchronously mid-cycle while wr_en = 0x8 -> busy = 0 next cycle and no wr_en pulse for the dropped entries; wr_en goes to 0 immediately, without waiting for a clock edge.
